// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 low-word multiplier: one external-ALU add per cycle, then an OR-with-zero for the flag.
// Start-to-done k+2 cycles (k = 1..32 RUN iterations); start is only taken in IDLE, never queued.
module alu_mul_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] mcand,
   input  logic [31:0] mplier,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_z,
   input  logic        alu_ex
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLAG, S_DONE} state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mc_q, mc_d;
   logic [31:0] mp_q, mp_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] result_q, result_d;
   logic        zero_q, zero_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // ALU drive decodes only state and registers, so alu_z never loops back into it.
   always_comb begin
      alu_a  = 32'd0;
      alu_b  = 32'd0;
      alu_op = OP_AND;
      case (state_q)
         S_RUN: begin
            alu_a  = acc_q;
            alu_b  = mc_q;
            alu_op = OP_ADD;
         end
         S_FLAG: begin
            alu_a  = acc_q;
            alu_b  = 32'd0;
            alu_op = OP_OR;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mc_d     = mc_q;
      mp_d     = mp_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = 32'd0;
               mc_d    = mcand;
               mp_d    = mplier;
               cnt_d   = 5'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (mp_q[0]) begin
               acc_d = alu_z;
            end
            mc_d  = {mc_q[30:0], 1'b0};
            mp_d  = {1'b0, mp_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            // Stop as soon as no multiplier bits remain above the one just consumed.
            if (cnt_q == 5'd31 || mp_q[31:1] == 31'd0) begin
               state_d = S_FLAG;
            end
         end
         S_FLAG: begin
            result_d = alu_z;
            zero_d   = alu_ex;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= 32'd0;
         mc_q     <= 32'd0;
         mp_q     <= 32'd0;
         cnt_q    <= 5'd0;
         result_q <= 32'd0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mc_q     <= mc_d;
         mp_q     <= mp_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural ALU and an arithmetic reference model.
// Cycle n=1 is the first cycle after the edge that accepts start; done is expected in cycle k+2.
module tb_alu_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_z;
   logic        alu_ex;

   int vectors     = 0;
   int miscompares = 0;

   alu_mul_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mcand  (mcand),
      .mplier (mplier),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero),
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alu_op (alu_op),
      .alu_z  (alu_z),
      .alu_ex (alu_ex)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (alu_op)
         3'b000:  alu_z = alu_a & alu_b;
         3'b001:  alu_z = alu_a | alu_b;
         3'b010:  alu_z = alu_a + alu_b;
         3'b110:  alu_z = alu_a - alu_b;
         default: alu_z = 32'd0;
      endcase
      alu_ex = (alu_z == 32'd0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int run_len(input logic [31:0] m);
      int k = 1;
      for (int i = 0; i < 32; i++) begin
         if (m[i]) k = i + 1;
      end
      return k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [31:0] ma, input logic [31:0] mb);
      mcand  = ma;
      mplier = mb;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   // Walks cycles 1..k+2 of an accepted operation, checking ALU drive and outputs each cycle.
   task automatic follow(input logic [31:0] ma, input logic [31:0] mb, input string tag,
                         input int inj_run, input bit hold_done,
                         input logic [31:0] na, input logic [31:0] nb);
      int          k    = run_len(mb);
      logic [31:0] prod = ma * mb;
      logic [63:0] mask;
      for (int n = 1; n <= k + 2; n++) begin
         if (n <= k) begin
            mask = (64'd1 << (n - 1)) - 64'd1;
            check({tag, "_run_op"}, {29'd0, alu_op}, 32'h2);
            check({tag, "_run_a"}, alu_a, 32'((64'(ma) * (64'(mb) & mask))));
            check({tag, "_run_b"}, alu_b, ma << (n - 1));
         end else if (n == k + 1) begin
            check({tag, "_flag_op"}, {29'd0, alu_op}, 32'h1);
            check({tag, "_flag_a"}, alu_a, prod);
            check({tag, "_flag_b"}, alu_b, 32'd0);
         end else begin
            check({tag, "_done_op"}, {29'd0, alu_op}, 32'h0);
            check({tag, "_done_a"}, alu_a, 32'd0);
            check({tag, "_done_b"}, alu_b, 32'd0);
            check({tag, "_result"}, result, prod);
            check({tag, "_zero"}, {31'd0, zero}, {31'd0, prod == 32'd0});
         end
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_done"}, {31'd0, done}, {31'd0, n == k + 2});
         if (inj_run != 0 && n == inj_run) begin
            start  = 1'b1;
            mcand  = $urandom;
            mplier = $urandom;
         end else if (inj_run != 0 && n == inj_run + 1) begin
            start = 1'b0;
         end
         if (hold_done && n == k + 2) begin
            start  = 1'b1;
            mcand  = na;
            mplier = nb;
         end
         if (n < k + 2) tick();
      end
   endtask

   task automatic after_done(input logic [31:0] prod, input string tag);
      tick();
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      check({tag, "_hold_result"}, result, prod);
      check({tag, "_hold_zero"}, {31'd0, zero}, {31'd0, prod == 32'd0});
   endtask

   task automatic run_op(input logic [31:0] ma, input logic [31:0] mb, input string tag);
      launch(ma, mb);
      follow(ma, mb, tag, 0, 1'b0, 32'd0, 32'd0);
      after_done(ma * mb, tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      reset  = 1'b1;
      start  = 1'b1;
      mcand  = 32'd6;
      mplier = 32'd7;
      tick();
      tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_op", {29'd0, alu_op}, 32'd0);
      start = 1'b0;
      reset = 1'b0;
      tick();

      run_op(32'd6, 32'd7, "basic");
      run_op(32'd0, 32'd0, "zeros");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "full");
      run_op(32'h0001_0000, 32'h0001_0000, "wrap");
      run_op(32'hDEAD_BEEF, 32'd1, "one");
      run_op(32'h8000_0001, 32'h8000_0000, "top_bit");

      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_op(ra, rb, "rand");
      end

      // start during RUN is dropped; start raised in DONE and held is taken on the first IDLE edge
      launch(32'd1000, 32'h0000_0F0F);
      follow(32'd1000, 32'h0000_0F0F, "busy_start", 3, 1'b1, 32'd9, 32'd3);
      tick();
      check("held_idle_busy", {31'd0, busy}, 32'd0);
      check("held_idle_done", {31'd0, done}, 32'd0);
      check("held_idle_result", result, 32'd1000 * 32'h0F0F);
      tick();
      start = 1'b0;
      follow(32'd9, 32'd3, "held", 0, 1'b0, 32'd0, 32'd0);
      after_done(32'd27, "held");

      launch(32'h1234_5678, 32'hFFFF_FFFF);
      for (int n = 1; n < 10; n++) begin
         check("midrst_run_done", {31'd0, done}, 32'd0);
         tick();
      end
      reset = 1'b1;
      tick();
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_zero", {31'd0, zero}, 32'd0);
      check("midrst_alu_a", alu_a, 32'd0);
      check("midrst_alu_b", alu_b, 32'd0);
      check("midrst_alu_op", {29'd0, alu_op}, 32'd0);
      reset = 1'b0;
      run_op(32'd3, 32'd5, "post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
